// File: rtl/pll_lock_monitor_if.sv
// PLL lock monitor signal bundle: toggle input from the PLL domain,
// frequency report and lock/restart outputs.
`timescale 1ns/1ps
interface pll_lock_monitor_if #(
  parameter int CNT_W = 16
);
  logic             clk_tgl;
  logic [CNT_W-1:0] freq_cnt;
  logic             cnt_valid;
  logic             locked;
  logic             lock_lost;
  logic             pll_reset;

  modport master (
    input  clk_tgl,
    output freq_cnt,
    output cnt_valid,
    output locked,
    output lock_lost,
    output pll_reset
  );

  modport slave (
    output clk_tgl,
    input  freq_cnt,
    input  cnt_valid,
    input  locked,
    input  lock_lost,
    input  pll_reset
  );
endinterface

// File: rtl/pll_lock_monitor.sv
// Frequency checker and lock supervisor for the PLL output clock,
// measured on refclk; restarts the PLL after repeated failed acquisition.
`timescale 1ns/1ps
module pll_lock_monitor #(
  parameter int WINDOW       = 1250,
  parameter int EXP_CNT      = 750,
  parameter int TOL          = 8,
  parameter int GOOD_WINDOWS = 4,
  parameter int MAX_ACQ      = 8,
  parameter int RST_CYCLES   = 16,
  parameter int CNT_W        = 16
) (
  input  logic refclk,
  input  logic reset_n,
  pll_lock_monitor_if.master bus
);

  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam int RUN_W = $clog2(GOOD_WINDOWS + 1);
  localparam int ACQ_W = $clog2(MAX_ACQ + 1);
  localparam int RC_W  = $clog2(RST_CYCLES + 1);
  localparam int CMP_W = (CNT_W + 1 > 32) ? CNT_W + 1 : 32;

  localparam logic [CMP_W-1:0] LO =
    (EXP_CNT > TOL) ? CMP_W'(EXP_CNT - TOL) : '0;
  localparam logic [CMP_W-1:0] HI =
    CMP_W'(EXP_CNT + TOL);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ACQ,
    LOCKED,
    RESTART
  } state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] tr_cnt;
  logic [RUN_W-1:0] good_run;
  logic [ACQ_W-1:0] acq_fail;
  logic [RC_W-1:0]  rst_cnt;
  logic [CNT_W-1:0] freq_q;
  logic             valid_q;
  logic             locked_q;
  logic             lost_q;
  logic             prst_q;

  logic             trans;
  logic [CNT_W-1:0] tr_nxt;
  logic [CMP_W-1:0] cnt_ext;
  logic             win_end;
  logic             good;

  assign trans   = s2 ^ s3;
  assign tr_nxt  = (trans && tr_cnt != CNT_MAX)
                 ? tr_cnt + CNT_W'(1) : tr_cnt;
  assign cnt_ext = CMP_W'(tr_nxt);
  assign win_end = (win_cnt == WIN_W'(WINDOW - 1));
  // a saturated count means the input ran too fast
  assign good    = (tr_nxt != CNT_MAX)
                 && (cnt_ext >= LO)
                 && (cnt_ext <= HI);

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ACQ;
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      win_cnt  <= '0;
      tr_cnt   <= '0;
      good_run <= '0;
      acq_fail <= '0;
      rst_cnt  <= '0;
      freq_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
      prst_q   <= 1'b0;
    end else begin
      s1      <= bus.clk_tgl;
      s2      <= s1;
      s3      <= s2;
      valid_q <= 1'b0;
      lost_q  <= 1'b0;
      unique case (state)
        RESTART: begin
          win_cnt  <= '0;
          tr_cnt   <= '0;
          good_run <= '0;
          acq_fail <= '0;
          if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
            state   <= ACQ;
            prst_q  <= 1'b0;
            rst_cnt <= '0;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end
        ACQ, LOCKED: begin
          if (win_end) begin
            win_cnt <= '0;
            tr_cnt  <= '0;
            freq_q  <= tr_nxt;
            valid_q <= 1'b1;
            unique case (1'b1)
              (state == LOCKED) && good: ;
              (state == LOCKED) && !good: begin
                state    <= ACQ;
                locked_q <= 1'b0;
                lost_q   <= 1'b1;
                good_run <= '0;
                acq_fail <= '0;
              end
              (state == ACQ) && good: begin
                acq_fail <= '0;
                if (good_run == RUN_W'(GOOD_WINDOWS - 1)) begin
                  state    <= LOCKED;
                  locked_q <= 1'b1;
                  good_run <= '0;
                end else begin
                  good_run <= good_run + RUN_W'(1);
                end
              end
              default: begin
                good_run <= '0;
                if (acq_fail == ACQ_W'(MAX_ACQ - 1)) begin
                  state    <= RESTART;
                  prst_q   <= 1'b1;
                  acq_fail <= '0;
                end else begin
                  acq_fail <= acq_fail + ACQ_W'(1);
                end
              end
            endcase
          end else begin
            win_cnt <= win_cnt + WIN_W'(1);
            tr_cnt  <= tr_nxt;
          end
        end
        default: state <= ACQ;
      endcase
    end
  end

  assign bus.freq_cnt  = freq_q;
  assign bus.cnt_valid = valid_q;
  assign bus.locked    = locked_q;
  assign bus.lock_lost = lost_q;
  assign bus.pll_reset = prst_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor: exact window counts, nominal
// and slow async sources, loss, restart, saturation, mid-run reset.
`timescale 1ns/1ps
module tb_pll_lock_monitor;

  logic    refclk  = 1'b0;
  logic    reset_n = 1'b0;
  logic    tgl_det = 1'b0;
  logic    tgl_async = 1'b0;
  logic    async_on = 1'b0;
  bit      det_on = 1'b0;
  realtime thalf = 13.333;
  int      ecnt;
  int      nvec = 0;
  int      nerr = 0;
  int      dp, dk;

  typedef struct {
    int n;
    int fc;
    bit lk;
    bit ll;
  } vec_t;

  vec_t tab[14];

  pll_lock_monitor_if bus ();
  pll_lock_monitor_if #(.CNT_W(8)) sbus ();

  assign bus.clk_tgl  = async_on ? tgl_async : tgl_det;
  assign sbus.clk_tgl = bus.clk_tgl;

  pll_lock_monitor dut (
    .refclk  (refclk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  pll_lock_monitor #(.CNT_W(8)) dut_sat (
    .refclk  (refclk),
    .reset_n (reset_n),
    .bus     (sbus)
  );

  always #4 refclk = ~refclk;

  always begin
    #(thalf);
    tgl_async = ~tgl_async;
  end

  always @(posedge refclk or negedge reset_n)
    if (!reset_n) ecnt <= 0;
    else          ecnt <= ecnt + 1;

  // window k gets tab[k].n toggles, one per cycle from its start
  always @(negedge refclk) begin
    if (det_on && reset_n && ecnt >= 1) begin
      dp = ecnt - 1;
      dk = dp / 1250;
      if (dk < 14 && (dp % 1250) < tab[dk].n)
        tgl_det = ~tgl_det;
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    nvec++;
    if (act < lo || act > hi) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic wait_valid(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge refclk);
      n++;
    end while (!bus.cnt_valid && n < limit);
    chk("cnt_valid_seen", 64'(bus.cnt_valid), 64'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_freq"},   64'(bus.freq_cnt),  64'd0);
    chk({tag, "_valid"},  64'(bus.cnt_valid), 64'd0);
    chk({tag, "_locked"}, 64'(bus.locked),    64'd0);
    chk({tag, "_lost"},   64'(bus.lock_lost), 64'd0);
    chk({tag, "_prst"},   64'(bus.pll_reset), 64'd0);
  endtask

  task automatic do_reset(input bit use_async);
    @(negedge refclk);
    reset_n  = 1'b0;
    det_on   = 1'b0;
    tgl_det  = 1'b0;
    async_on = use_async;
    repeat (4) @(negedge refclk);
    reset_n = 1'b1;
  endtask

  initial begin
    int n, nv;

    tab[0]  = '{742, 742, 1'b0, 1'b0};
    tab[1]  = '{758, 758, 1'b0, 1'b0};
    tab[2]  = '{750, 750, 1'b0, 1'b0};
    tab[3]  = '{741, 741, 1'b0, 1'b0};
    tab[4]  = '{758, 758, 1'b0, 1'b0};
    tab[5]  = '{742, 742, 1'b0, 1'b0};
    tab[6]  = '{751, 751, 1'b0, 1'b0};
    tab[7]  = '{750, 750, 1'b1, 1'b0};
    tab[8]  = '{759, 759, 1'b0, 1'b1};
    tab[9]  = '{749, 749, 1'b0, 1'b0};
    tab[10] = '{750, 750, 1'b0, 1'b0};
    tab[11] = '{750, 750, 1'b0, 1'b0};
    tab[12] = '{750, 750, 1'b1, 1'b0};
    tab[13] = '{0,   0,   1'b0, 1'b1};

    repeat (3) @(negedge refclk);
    chk_zero("reset");

    // exact per-window counts, synchronous to refclk
    do_reset(1'b0);
    det_on = 1'b1;
    for (int k = 0; k < 14; k++) begin
      wait_valid(1300);
      chk($sformatf("w%0d_cycle", k), 64'(ecnt), 64'(1250 * (k + 1)));
      chk($sformatf("w%0d_freq", k), 64'(bus.freq_cnt), 64'(tab[k].fc));
      chk($sformatf("w%0d_locked", k), 64'(bus.locked), 64'(tab[k].lk));
      chk($sformatf("w%0d_lost", k), 64'(bus.lock_lost), 64'(tab[k].ll));
      chk($sformatf("w%0d_prst", k), 64'(bus.pll_reset), 64'd0);
      @(negedge refclk);
      chk($sformatf("w%0d_valid_1cyc", k), 64'(bus.cnt_valid), 64'd0);
      chk($sformatf("w%0d_lost_1cyc", k), 64'(bus.lock_lost), 64'd0);
    end

    // nominal 75 MHz / 2
    thalf = 13.333;
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_valid(1300);
      chk($sformatf("nom%0d_cycle", i), 64'(ecnt), 64'(1250 * (i + 1)));
      // the first window misses the synchronizer fill cycles
      chk_rng($sformatf("nom%0d_freq", i), int'(bus.freq_cnt),
              (i == 0) ? 747 : 749, 751);
      chk($sformatf("nom%0d_locked", i), 64'(bus.locked), 64'(i == 3));
      chk($sformatf("nom%0d_prst", i), 64'(bus.pll_reset), 64'd0);
      if (i == 0) begin
        chk("sat_valid", 64'(sbus.cnt_valid), 64'd1);
        chk("sat_freq", 64'(sbus.freq_cnt), 64'd255);
      end
      chk($sformatf("sat%0d_locked", i), 64'(sbus.locked), 64'd0);
    end
    repeat (600) @(negedge refclk);
    chk("mid_cycle", 64'(ecnt), 64'd5600);
    chk("mid_locked", 64'(bus.locked), 64'd1);
    reset_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    repeat (3) @(negedge refclk);
    reset_n = 1'b1;
    wait_valid(1300);
    chk("mid_rel_cycle", 64'(ecnt), 64'd1250);
    chk_rng("mid_rel_freq", int'(bus.freq_cnt), 747, 751);

    // slow 60 MHz / 2 source forces restarts
    thalf = 16.667;
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) begin
      wait_valid(1300);
      chk($sformatf("slow%0d_cycle", i), 64'(ecnt), 64'(1250 * (i + 1)));
      chk_rng($sformatf("slow%0d_freq", i), int'(bus.freq_cnt), 595, 605);
      chk($sformatf("slow%0d_locked", i), 64'(bus.locked), 64'd0);
      chk($sformatf("slow%0d_prst", i), 64'(bus.pll_reset), 64'(i == 7));
    end
    n  = 1;
    nv = 0;
    repeat (100) begin
      @(negedge refclk);
      if (!bus.pll_reset) break;
      n++;
      if (bus.cnt_valid) nv++;
    end
    chk("prst_width", 64'(n), 64'd16);
    chk("prst_no_valid", 64'(nv), 64'd0);
    chk("prst_fall_cycle", 64'(ecnt), 64'd10016);
    wait_valid(1300);
    chk("post_rst_cycle", 64'(ecnt), 64'd11266);
    chk("post_rst_prst", 64'(bus.pll_reset), 64'd0);
    repeat (11000) begin
      @(negedge refclk);
      if (bus.pll_reset) break;
    end
    chk("prst2_rise", 64'(bus.pll_reset), 64'd1);
    chk("prst2_cycle", 64'(ecnt), 64'd20016);
    repeat (4) @(negedge refclk);
    chk("prst2_high", 64'(bus.pll_reset), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_in_restart_prst", 64'(bus.pll_reset), 64'd0);
    chk("rst_in_restart_freq", 64'(bus.freq_cnt), 64'd0);
    repeat (3) @(negedge refclk);
    reset_n = 1'b1;
    wait_valid(1300);
    chk("restart_rel_cycle", 64'(ecnt), 64'd1250);
    chk("restart_rel_prst", 64'(bus.pll_reset), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pll_lock_monitor.md
# pll_lock_monitor

Single-clock frequency checker and lock supervisor for the 75 MHz clock produced by the system PLL from the 125 MHz reference. Runs on `refclk` and counts transitions of a divide-by-2 toggle generated in the PLL output domain over a fixed reference window. It declares lock after consecutive in-tolerance windows. If acquisition fails repeatedly, it drives the PLL's active-high `reset` input with a fixed-width pulse to restart it.

## Interface
- `WINDOW`, 1250: window length in `refclk` cycles (10 µs).
- `EXP_CNT`, 750: expected toggle transitions per window.
- `TOL`, 8: allowed absolute deviation from `EXP_CNT`, inclusive.
- `GOOD_WINDOWS`, 4: consecutive good windows required to lock.
- `MAX_ACQ`, 8: bad windows in ACQ before a PLL restart.
- `RST_CYCLES`, 16: width of the `pll_reset` pulse.
- `CNT_W`, 16: width of the counters and `freq_cnt`.
- `refclk` in 1: 125 MHz reference; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `clk_tgl` in 1: flop toggling on every PLL-output rising edge; asynchronous to `refclk`.
- `freq_cnt` out CNT_W: transitions counted in the last completed window.
- `cnt_valid` out 1: one-cycle pulse when `freq_cnt` updates.
- `locked` out 1: PLL output frequency verified.
- `lock_lost` out 1: one-cycle pulse on the LOCKED→ACQ transition.
- `pll_reset` out 1: active-high reset to the PLL.

## Operation
- Input path:
  - Two-flop synchronizer on `clk_tgl`, then a third flop.
  - Transition = s2 XOR s3.
- Edge counter:
  - Increments on each transition.
  - Saturates at 2^CNT_W−1; it never wraps.
- Window counter:
  - Counts 0..WINDOW−1, then wraps to 0.
- Window close (window counter == WINDOW−1):
  - `freq_cnt` ← edge count, including a transition in that same cycle.
  - Edge counter ← 0.
  - `cnt_valid` = 1 on the next cycle.
- Good window: |freq_cnt − EXP_CNT| ≤ TOL. Compare unsigned, using the wider of CNT_W+1 bits; no underflow is allowed.
- States:
  - **ACQ** (reset state):
    - Good window: good_run++, acq_fail = 0.
    - Bad window: good_run = 0, acq_fail++.
    - good_run == GOOD_WINDOWS → LOCKED.
    - acq_fail == MAX_ACQ → RESTART.
  - **LOCKED**:
    - `locked` = 1.
    - Good windows: no change.
    - Any single bad window → ACQ, `locked` = 0, `lock_lost` pulse, good_run = acq_fail = 0.
  - **RESTART**:
    - `pll_reset` = 1 for exactly RST_CYCLES cycles.
    - Window counter, edge counter, good_run and acq_fail are held at 0; transitions are ignored.
    - No `cnt_valid` is issued.
    - Then → ACQ, and a fresh window starts at count 0.
- Decisions use the window being closed. The state change, `locked`, `lock_lost` and `cnt_valid` all take effect together in the same cycle.
- Simultaneous events:
  - If good_run reaches GOOD_WINDOWS on the same window that would otherwise be evaluated, lock wins. A good window always clears acq_fail.
  - A transition in the closing cycle is counted in the closing window, never the next.
- Edge-count saturation yields a bad window (too fast).

## Timing
- All outputs are registered.
- Reset values:
  - `freq_cnt` = 0, `cnt_valid` = 0, `locked` = 0, `lock_lost` = 0, `pll_reset` = 0.
  - State = ACQ; all counters = 0.
- Asserting `reset_n` mid-window or mid-RESTART:
  - Aborts immediately and returns to reset values.
  - `pll_reset` drops asynchronously.
- Input latency: 3 `refclk` cycles from a `clk_tgl` change to edge-counter increment.
- First `cnt_valid`: cycle WINDOW after reset release.
- Earliest `locked`: cycle GOOD_WINDOWS·WINDOW (5000) after reset release.
- RESTART:
  - `pll_reset` rises on the cycle of the MAX_ACQ-th bad `cnt_valid`.
  - Falls RST_CYCLES cycles later.
  - The next window closes WINDOW cycles after the fall.
- Input constraint: `clk_tgl` frequency must be below `refclk`/2 (62.5 MHz); nominal is 37.5 MHz.

## Test plan
- Nominal: drive `clk_tgl` from a 75 MHz clock ÷2.
  - Every `freq_cnt` is in 749..751.
  - `cnt_valid` every 1250 cycles.
  - `locked` rises with the 4th `cnt_valid`.
  - `pll_reset` is never asserted.
- Tolerance edges: drive deterministic transition counts synchronous to `refclk`.
  - 742 and 758 are good; 741 and 759 are bad.
  - Check `locked` for the pattern good×3, bad, good×4: locked only after the 8th window.
- Loss: after lock, stop `clk_tgl`.
  - Next window gives `freq_cnt` = 0.
  - `locked` falls, with a one-cycle `lock_lost` pulse in the same cycle.
- Restart: drive a 60 MHz source ÷2 (freq_cnt ≈ 600).
  - After 8 windows, `pll_reset` is high for exactly 16 cycles.
  - No `cnt_valid` is issued during the pulse.
  - The sequence repeats every 8·1250+16 cycles.
- Saturation: set CNT_W=8 with a nominal input.
  - `freq_cnt` = 255; the window is bad; `locked` never rises.
- Reset mid-operation: assert `reset_n` low at window cycle 600 while LOCKED, and separately during RESTART.
  - All outputs return to 0 immediately.
  - First `cnt_valid` is 1250 cycles after release.
